// File: rtl/ysyx_lsu.sv
// Load/store unit: one RISC-V load or store at a time, aligned onto a word-wide memory bus.
// Latency: accept at T, bus request from T+1, result at T+3 on a zero-wait bus; errors report at T+1.
// Backpressure: in_ready only in IDLE; request and result fields held stable until mem_req_ready / out_ready.
module ysyx_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     wmask_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    logic [OFS-1:0]    in_ofs;
    logic              misalign;
    logic              illegal;
    logic              in_err;
    logic [NB-1:0]     size_mask;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_data;

    // Classify the incoming operation: byte-lane mask for its size, alignment and legality
    always_comb begin
        in_ofs  = in_addr[OFS-1:0];
        illegal = (in_funct3 == 3'b111)
                || (in_we && in_funct3[2])
                || ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
        case (in_funct3[1:0])
            2'b00: begin
                misalign  = 1'b0;
                size_mask = NB'(1);
            end
            2'b01: begin
                misalign  = in_addr[0];
                size_mask = NB'(3);
            end
            2'b10: begin
                misalign  = |in_addr[1:0];
                size_mask = NB'(15);
            end
            default: begin
                misalign  = |in_addr[2:0];
                size_mask = '1;
            end
        endcase
        in_err = illegal || misalign;
    end

    // Pull the addressed bytes down to bit 0 and extend them to XLEN
    always_comb begin
        ld_shift = mem_rsp_rdata >> {addr_q[OFS-1:0], 3'b000};
        case (f3_q[1:0])
            2'b00:   ld_data = f3_q[2] ? XLEN'(ld_shift[7:0])  : XLEN'($signed(ld_shift[7:0]));
            2'b01:   ld_data = f3_q[2] ? XLEN'(ld_shift[15:0]) : XLEN'($signed(ld_shift[15:0]));
            2'b10:   ld_data = f3_q[2] ? XLEN'(ld_shift[31:0]) : XLEN'($signed(ld_shift[31:0]));
            default: ld_data = ld_shift;
        endcase
    end

    // State register; reset wins over everything and drops any outstanding response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: errored operations skip the bus and go straight to the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = in_err ? RESP : REQ;
            REQ:     if (mem_req_ready) state_d = WAIT;
            WAIT:    if (mem_rsp_valid) state_d = RESP;
            default: if (out_ready)     state_d = IDLE;
        endcase
    end

    // Operation capture in IDLE and load-result capture in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && in_valid) begin
                we_q    <= in_we;
                f3_q    <= in_funct3;
                addr_q  <= in_addr;
                err_q   <= in_err;
                rdata_q <= '0;
                wdata_q <= in_we ? (in_wdata << {in_ofs, 3'b000}) : '0;
                wmask_q <= in_we ? (size_mask << in_ofs) : '0;
            end
            if ((state_q == WAIT) && mem_rsp_valid && !we_q) begin
                rdata_q <= ld_data;
            end
        end
    end

    // Outputs decoded from state; result and mask are forced to zero outside their phase
    always_comb begin
        in_ready      = (state_q == IDLE);
        mem_req_valid = (state_q == REQ);
        mem_we        = we_q;
        mem_addr      = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
        mem_wdata     = wdata_q;
        mem_wmask     = (state_q == REQ) ? wmask_q : '0;
        out_valid     = (state_q == RESP);
        out_rdata     = (state_q == RESP) ? rdata_q : '0;
        out_err       = (state_q == RESP) && err_q;
    end

endmodule
